// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter: shared 4-bit maximal-length Fibonacci LFSR served
// round-robin to NUM_REQ requesters, one value per grant, with seeding
// and a post-reset / post-seed warm-up phase.
//
// Handshake: req[i] is a level request held until served. The grant
// appears registered: req sampled at edge k yields gnt/rnd/rnd_valid for
// the cycle after edge k. A requester must drop req in the cycle after it
// sees its gnt bit, otherwise the still-high req counts as a new request.
// There is no back-pressure; rnd is only meaningful while rnd_valid is 1.
module lfsr_rng_arbiter #(
  parameter int         NUM_REQ = 4,
  parameter logic [3:0] SEED    = 4'b0001,
  parameter int         WARMUP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_load,
  input  logic [3:0]         seed_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [3:0]         rnd,
  output logic               rnd_valid,
  output logic               busy,
  output logic               fsm_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_WARMUP = 1'b0,
    S_IDLE   = 1'b1
  } state_t;

  // With no warm-up requested the block comes up ready to grant.
  localparam state_t     START_STATE = (WARMUP == 0) ? S_IDLE : S_WARMUP;
  localparam logic       START_BUSY  = (WARMUP != 0);
  localparam logic [7:0] LAST_CNT    = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  state_t          state;
  logic [3:0]      lfsr;
  logic [7:0]      cnt;
  logic [PW-1:0]   rr_ptr;

  logic [3:0]         lfsr_next;
  logic [PW-1:0]      winner;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] onehot;
  logic               found;
  logic [PW-1:0]      cand;
  int                 idx;

  // Fibonacci step; taps chosen so the sequence has period 15 and never
  // reaches all-zero from a non-zero start.
  assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

  assign fsm_state = state;

  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ptr_next = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
  assign onehot   = NUM_REQ'(1) << winner;

  // Single FSM: reset, seed load, warm-up stepping and grant issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      cnt       <= 8'd0;
      rr_ptr    <= '0;
      gnt       <= '0;
      rnd       <= 4'd0;
      rnd_valid <= 1'b0;
      state     <= START_STATE;
      busy      <= START_BUSY;
    end else if (seed_load) begin
      // A zero seed would lock the LFSR, so substitute the default.
      lfsr      <= (seed_in == 4'd0) ? SEED : seed_in;
      cnt       <= 8'd0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      state     <= START_STATE;
      busy      <= START_BUSY;
    end else begin
      case (state)
        S_WARMUP: begin
          lfsr      <= lfsr_next;
          cnt       <= cnt + 8'd1;
          gnt       <= '0;
          rnd_valid <= 1'b0;
          if (cnt == LAST_CNT) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (found) begin
            gnt       <= onehot;
            rnd       <= lfsr;
            rnd_valid <= 1'b1;
            lfsr      <= lfsr_next;
            rr_ptr    <= ptr_next;
          end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
          end
        end
        default: begin
          state <= START_STATE;
          busy  <= START_BUSY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter (NUM_REQ=4, SEED=0001, WARMUP=2).
module tb_lfsr_rng_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       seed_load;
  logic [3:0] seed_in;
  logic [3:0] gnt;
  logic [3:0] rnd;
  logic       rnd_valid;
  logic       busy;
  logic       fsm_state;

  int checks = 0;
  int errors = 0;

  // Hand-derived LFSR sequence starting from the value after two warm-up
  // steps of seed 0001: 0100 1001 0011 0110 1101 1010 0101 1011 0111 1111
  // 1110 1100 1000 0001 0010.
  logic [3:0] seq [0:14] = '{4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                             4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2};

  lfsr_rng_arbiter #(
    .NUM_REQ(4),
    .SEED(4'b0001),
    .WARMUP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .seed_load(seed_load),
    .seed_in(seed_in),
    .gnt(gnt),
    .rnd(rnd),
    .rnd_valid(rnd_valid),
    .busy(busy),
    .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle before sampling / driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset and let the two warm-up steps elapse (no checks here).
  task automatic reset_and_warm(input logic [3:0] r);
    rst = 1'b1;
    req = r;
    seed_load = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0001;
    seed_load = 1'b0;
    seed_in = 4'd0;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, rnd_valid, gnt, rnd} !== {1'b1, 1'b0, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b vld=%b gnt=%b rnd=%b, expected busy=1 vld=0 gnt=0000 rnd=0000",
               busy, rnd_valid, gnt, rnd);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({busy, rnd_valid, gnt} !== {(i == 0), 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL warmup%0d: got busy=%b vld=%b gnt=%b, expected busy=%b vld=0 gnt=0000",
                 i, busy, rnd_valid, gnt, (i == 0));
      end
    end
  endtask

  task automatic test_single_sequence();
    // Continues from test_reset: req=0001 held, block now idle.
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if ({busy, rnd_valid, gnt, rnd} !== {1'b0, 1'b1, 4'b0001, seq[i % 15]}) begin
        errors++;
        $display("FAIL single_seq%0d: got busy=%b vld=%b gnt=%b rnd=%b, expected busy=0 vld=1 gnt=0001 rnd=%b",
                 i, busy, rnd_valid, gnt, rnd, seq[i % 15]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    reset_and_warm(4'b1111);
    for (int i = 0; i < 5; i++) begin
      eg = 4'b0001 << (i % 4);
      step();
      checks++;
      if ({rnd_valid, gnt, rnd} !== {1'b1, eg, seq[i]}) begin
        errors++;
        $display("FAIL rr%0d: got vld=%b gnt=%b rnd=%b, expected vld=1 gnt=%b rnd=%b",
                 i, rnd_valid, gnt, rnd, eg, seq[i]);
      end
    end
  endtask

  task automatic test_seed_load();
    reset_and_warm(4'b0010);
    step();
    step();
    checks++;
    if ({gnt, rnd} !== {4'b0010, 4'h9}) begin
      errors++;
      $display("FAIL seed_pre: got gnt=%b rnd=%b, expected gnt=0010 rnd=1001", gnt, rnd);
    end
    seed_load = 1'b1;
    seed_in = 4'b1000;
    step();
    seed_load = 1'b0;
    checks++;
    if ({busy, rnd_valid, gnt, rnd} !== {1'b1, 1'b0, 4'b0000, 4'h9}) begin
      errors++;
      $display("FAIL seed_edge: got busy=%b vld=%b gnt=%b rnd=%b, expected busy=1 vld=0 gnt=0000 rnd=1001",
               busy, rnd_valid, gnt, rnd);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({busy, rnd_valid, gnt} !== {(i == 0), 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL seed_warm%0d: got busy=%b vld=%b gnt=%b, expected busy=%b vld=0 gnt=0000",
                 i, busy, rnd_valid, gnt, (i == 0));
      end
    end
    step();
    checks++;
    if ({rnd_valid, gnt, rnd} !== {1'b1, 4'b0010, 4'b0010}) begin
      errors++;
      $display("FAIL seed_first: got vld=%b gnt=%b rnd=%b, expected vld=1 gnt=0010 rnd=0010",
               rnd_valid, gnt, rnd);
    end
    step();
    checks++;
    if ({gnt, rnd} !== {4'b0010, 4'b0100}) begin
      errors++;
      $display("FAIL seed_second: got gnt=%b rnd=%b, expected gnt=0010 rnd=0100", gnt, rnd);
    end
  endtask

  task automatic test_zero_seed();
    req = 4'b0001;
    seed_load = 1'b1;
    seed_in = 4'b0000;
    step();
    seed_load = 1'b0;
    checks++;
    if ({busy, gnt} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL zseed_edge: got busy=%b gnt=%b, expected busy=1 gnt=0000", busy, gnt);
    end
    step();
    step();
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if ({rnd_valid, gnt, rnd} !== {1'b1, 4'b0001, seq[i]} || rnd == 4'd0) begin
        errors++;
        $display("FAIL zseed%0d: got vld=%b gnt=%b rnd=%b, expected vld=1 gnt=0001 rnd=%b",
                 i, rnd_valid, gnt, rnd, seq[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eg [0:6];
    logic [3:0] er [0:6];
    logic       ev [0:6];
    logic [3:0] rq [0:6];
    eg = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    er = '{4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hD, 4'hA};
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rq = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    reset_and_warm(4'b1010);
    for (int i = 0; i < 7; i++) begin
      req = rq[i];
      step();
      checks++;
      if ({busy, rnd_valid, gnt, rnd} !== {1'b0, ev[i], eg[i], er[i]}) begin
        errors++;
        $display("FAIL fair%0d: got busy=%b vld=%b gnt=%b rnd=%b, expected busy=0 vld=%b gnt=%b rnd=%b",
                 i, busy, rnd_valid, gnt, rnd, ev[i], eg[i], er[i]);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    reset_and_warm(4'b1111);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({gnt, rnd} !== {4'b0100, 4'h3}) begin
      errors++;
      $display("FAIL burst_pre: got gnt=%b rnd=%b, expected gnt=0100 rnd=0011", gnt, rnd);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, rnd_valid, gnt, rnd} !== {1'b1, 1'b0, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL burst_reset: got busy=%b vld=%b gnt=%b rnd=%b, expected busy=1 vld=0 gnt=0000 rnd=0000",
               busy, rnd_valid, gnt, rnd);
    end
    step();
    step();
    checks++;
    if ({busy, gnt} !== {1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL burst_warm: got busy=%b gnt=%b, expected busy=0 gnt=0000", busy, gnt);
    end
    step();
    checks++;
    if ({rnd_valid, gnt, rnd} !== {1'b1, 4'b0001, 4'b0100}) begin
      errors++;
      $display("FAIL burst_first: got vld=%b gnt=%b rnd=%b, expected vld=1 gnt=0001 rnd=0100",
               rnd_valid, gnt, rnd);
    end
    step();
    checks++;
    if ({rnd_valid, gnt, rnd} !== {1'b1, 4'b0010, 4'b1001}) begin
      errors++;
      $display("FAIL burst_second: got vld=%b gnt=%b rnd=%b, expected vld=1 gnt=0010 rnd=1001",
               rnd_valid, gnt, rnd);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    seed_load = 1'b0;
    seed_in = 4'b0000;
    test_reset();
    test_single_sequence();
    test_round_robin();
    test_seed_load();
    test_zero_seed();
    test_fairness();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
Shared pseudo-random number server. One internal 4-bit maximal-length Fibonacci LFSR is granted round-robin to NUM_REQ requesters, one 4-bit value per grant. The block also handles seeding and warm-up. It sits between the shared LFSR datapath and the blocks that need random values (test-pattern generators, backoff counters).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SEED, 4'b0001, LFSR value loaded on reset and substituted for an all-zero seed_in
WARMUP, 2, LFSR steps taken after reset or seed load before the first grant (0..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  level request per requester; held until granted
seed_load  input  1  one-cycle strobe: load seed_in into the LFSR
seed_in  input  4  new seed value
gnt  output  NUM_REQ  one-hot grant, valid one cycle
rnd  output  4  random value delivered with gnt
rnd_valid  output  1  high in the same cycle as a non-zero gnt
busy  output  1  high while warming up; no grants issued

Behaviour:
- LFSR step: next = {lfsr[2:0], lfsr[3]^lfsr[2]}. Period 15. All-zero is unreachable.
- FSM states: WARMUP, IDLE.
- Reset (rst=1 at an edge), all registered:
  - lfsr=SEED, cnt=0, rr_ptr=0, gnt=0, rnd=0, rnd_valid=0.
  - fsm=WARMUP, busy=1. If WARMUP=0, fsm=IDLE and busy=0.
- rst overrides seed_load and req.
- WARMUP:
  - Each edge: lfsr steps, cnt++. gnt/rnd_valid stay 0; req is ignored.
  - At the edge where cnt==WARMUP-1, go to IDLE and set busy=0. Exactly WARMUP steps are taken.
- IDLE, at each edge with no seed_load:
  - If req!=0: the winner is the first set bit searching from rr_ptr upward with wrap.
  - gnt <= one-hot(winner), rnd <= current lfsr, rnd_valid <= 1.
  - The LFSR steps once and rr_ptr <= (winner+1) mod NUM_REQ.
  - If req==0: gnt=0, rnd_valid=0, and rnd holds its last value. No LFSR step; rr_ptr is unchanged.
- Latency: req sampled at edge k produces gnt/rnd visible after edge k, for the cycle up to edge k+1.
- Back-to-back grants are allowed every cycle with no dead cycles.
- A requester must drop req in the cycle after seeing its gnt, or it is counted as a new request. A req dropped before it is granted is simply not served.
- seed_load=1 at an edge (any state, rst=0):
  - lfsr <= (seed_in==0 ? SEED : seed_in), cnt=0, fsm=WARMUP (or IDLE if WARMUP=0).
  - gnt=0, rnd_valid=0. rr_ptr is preserved.
  - Pending req in that cycle is not granted.
- Each distinct requester is granted at least once every NUM_REQ grants under continuous requests (no starvation).
- rnd changes only on a grant edge or on reset.

Test Plan:
1. Reset, WARMUP=2, req=0001 held: busy=1 for 2 cycles, then gnt=0001 every cycle with rnd=0100,1001,0011,0110,1101. After 15 grants the sequence repeats from 0100.
2. req=1111 held from IDLE after reset: gnt=0001,0010,0100,1000,0001 on consecutive cycles with rnd=0100,1001,0011,0110,1101. rnd_valid is continuously 1.
3. Mid-stream seed_load with seed_in=1000 while req=0010 held: that cycle gnt=0, then busy=1 for 2 cycles (1000->0001->0010). The next grant is gnt=0010 with rnd=0010.
4. seed_load with seed_in=0000: SEED substituted, so after warm-up the first rnd=0100. The LFSR never reaches 0000.
5. Fairness: req=1010 held, rr_ptr=0: gnt alternates 0010,1000,0010. Drop req[1] while req[3] is held: only 1000 is granted.
6. Reset mid-operation, req=1111 during a grant burst: outputs go to 0 on the next edge, rr_ptr=0, warm-up repeats. The first post-reset rnd=0100 goes to requester 0.
